// File: rtl/ste_shift_engine.sv
// ste_shift_engine
// ----------------
// Lane-oriented serialiser/deserialiser. A frame starts by loading a parallel
// word. Each enabled step then shifts one LANE_W-bit lane out and one lane in,
// MSB-first or LSB-first. The frame length is programmable up to STEPS lanes.
// A three-state FSM (IDLE -> SHIFT -> DONE) frames the transfer, and an abort
// clears the engine from any state.
//
// Ports:
//   clk              system clock
//   reset_ni         asynchronous reset, active low
//   start_i          load din_parallel_i and begin a frame (IDLE only)
//   abort_i          cancel frame, clear data and counter (highest priority)
//   din_parallel_i   parallel load word
//   din_i            serial input lane
//   shift_en_i       one lane shift per cycle while high in SHIFT
//   cfg_lsb_first_i  0 = MSB-first, 1 = LSB-first (sampled at start)
//   cfg_len_i        steps in the frame, clipped to STEPS (sampled at start)
//   dout_o           lane that leaves on this cycle's shift edge
//   dout_parallel_o  current shift register contents
//   busy_o           frame in progress (SHIFT or DONE)
//   done_o           single-cycle pulse at frame end
module ste_shift_engine #(
  parameter  int SHIFT_W = 16,
  parameter  int LANE_W  = 1,
  localparam int STEPS   = SHIFT_W / LANE_W,
  localparam int CNT_W   = $clog2(STEPS + 1)
) (
  input  logic               clk,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [SHIFT_W-1:0] din_parallel_i,
  input  logic [LANE_W-1:0]  din_i,
  input  logic               shift_en_i,
  input  logic               cfg_lsb_first_i,
  input  logic [CNT_W-1:0]   cfg_len_i,
  output logic [LANE_W-1:0]  dout_o,
  output logic [SHIFT_W-1:0] dout_parallel_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  generate
    if ((LANE_W < 1) || ((SHIFT_W % LANE_W) != 0)) begin : g_bad_lane
      $error("ste_shift_engine: SHIFT_W must be a positive multiple of LANE_W");
    end
  endgenerate

  logic [SHIFT_W-1:0] shift_ff;
  logic [CNT_W-1:0]   cnt_q;
  logic               dir_q;
  logic [1:0]         state_q;

  logic [SHIFT_W-1:0] shift_msb;
  logic [SHIFT_W-1:0] shift_lsb;
  logic [CNT_W-1:0]   len_eff;

  // When one lane fills the whole register, a step just replaces it with din_i.
  // A separate branch avoids a negative-width slice.
  generate
    if (LANE_W == SHIFT_W) begin : g_full_lane
      assign shift_msb = din_i;
      assign shift_lsb = din_i;
    end else begin : g_part_lane
      assign shift_msb = {shift_ff[SHIFT_W-LANE_W-1:0], din_i};
      assign shift_lsb = {din_i, shift_ff[SHIFT_W-1:LANE_W]};
    end
  endgenerate

  assign len_eff = (cfg_len_i > STEPS_C) ? STEPS_C : cfg_len_i;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      shift_ff <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else if (abort_i) begin
      // dir_q is deliberately kept; only data, count and state are cleared.
      shift_ff <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            shift_ff <= din_parallel_i;
            dir_q    <= cfg_lsb_first_i;
            cnt_q    <= len_eff;
            // A zero-length frame skips SHIFT and leaves the data unchanged.
            state_q  <= (len_eff == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_en_i) begin
            shift_ff <= dir_q ? shift_lsb : shift_msb;
            cnt_q    <= cnt_q - ONE_C;
            if (cnt_q == ONE_C) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout_o          = dir_q ? shift_ff[LANE_W-1:0] : shift_ff[SHIFT_W-1 -: LANE_W];
  assign dout_parallel_o = shift_ff;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);

endmodule
